truth_table_evaluator: RTL

- Sequential evaluator for evolved combinational candidate circuits: the hardware end that reads a configured candidate back.
- Sweeps every input vector into the candidate (device under evaluation, DUE), waits a settle interval, and samples the outputs into a truth table.
- Sends the table to the host GA software as a framed UART (8N1) byte stream.
- Sits between the candidate grid and the host serial link.

---
 rtl/truth_table_evaluator.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/truth_table_evaluator.sv
// Sweeps every input vector through a candidate circuit, captures its truth table,
// and ships the table to the host as a framed 8N1 UART byte stream.
module truth_table_evaluator #(
  parameter int unsigned N_IN         = 3,
  parameter int unsigned N_OUT        = 2,
  parameter int unsigned SETTLE       = 4,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic [N_IN-1:0]               due_in,
  input  logic [N_OUT-1:0]              due_out,
  output logic [N_OUT*(2**N_IN)-1:0]    truth_table,
  output logic                          tx,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned N_VEC  = 2**N_IN;
  localparam int unsigned TT_W   = N_OUT * N_VEC;
  localparam int unsigned NB     = (TT_W + 7) / 8;
  localparam int unsigned PAD_W  = NB * 8;
  localparam int unsigned BYTE_W = $clog2(NB + 1);
  localparam int unsigned BT_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned ST_W   = $clog2(SETTLE + 1);
  localparam int unsigned VEC_W  = N_IN + 1;

  typedef enum logic [2:0] {
    IDLE, DRIVE, SAMPLE, LOAD, TX_START, TX_DATA, TX_STOP, FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [N_IN-1:0]   due_in_q, due_in_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic [ST_W-1:0]   settle_q, settle_d;
  logic [BT_W-1:0]   bit_tmr_q, bit_tmr_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [PAD_W-1:0]  tt_pad;
  logic [7:0]        frame_byte;
  logic              bit_end;
  logic              last_vec;
  logic              last_byte;

  assign bit_end   = (bit_tmr_q == BT_W'(CLKS_PER_BIT - 1));
  assign last_vec  = (vec_q == VEC_W'(N_VEC - 1));
  assign last_byte = (byte_q == BYTE_W'(NB));

  // Frame byte 0 is the header; byte j>0 is table byte j-1, zero-padded above the MSB.
  always_comb begin
    tt_pad     = PAD_W'(tt_q);
    frame_byte = HEADER;
    for (int unsigned j = 1; j <= NB; j++) begin
      if (byte_q == BYTE_W'(j)) frame_byte = tt_pad[(j-1)*8 +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    due_in_d  = due_in_q;
    tt_d      = tt_q;
    settle_d  = settle_q;
    bit_tmr_d = bit_tmr_q;
    bit_idx_d = bit_idx_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = DRIVE;
          vec_d    = '0;
          due_in_d = '0;
          tt_d     = '0;
          settle_d = '0;
          busy_d   = 1'b1;
        end
      end
      DRIVE: begin
        if (settle_q == ST_W'(SETTLE - 1)) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      SAMPLE: begin
        for (int unsigned v = 0; v < N_VEC; v++) begin
          if (vec_q[N_IN-1:0] == N_IN'(v)) tt_d[v*N_OUT +: N_OUT] = due_out;
        end
        if (last_vec) begin
          byte_d  = '0;
          state_d = LOAD;
        end else begin
          vec_d    = vec_q + 1'b1;
          due_in_d = due_in_q + 1'b1;
          state_d  = DRIVE;
        end
      end
      LOAD: begin
        // tx is registered, so each line level is set on entry to the state that owns it.
        shift_d   = frame_byte;
        bit_tmr_d = '0;
        tx_d      = 1'b0;
        state_d   = TX_START;
      end
      TX_START: begin
        if (bit_end) begin
          bit_tmr_d = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          state_d   = TX_DATA;
        end else begin
          bit_tmr_d = bit_tmr_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          bit_tmr_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = TX_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          bit_tmr_d = bit_tmr_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          bit_tmr_d = '0;
          if (last_byte) begin
            done_d  = 1'b1;
            state_d = FINISH;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = LOAD;
          end
        end else begin
          bit_tmr_d = bit_tmr_q + 1'b1;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      due_in_q  <= '0;
      tt_q      <= '0;
      settle_q  <= '0;
      bit_tmr_q <= '0;
      bit_idx_q <= '0;
      byte_q    <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      due_in_q  <= due_in_d;
      tt_q      <= tt_d;
      settle_q  <= settle_d;
      bit_tmr_q <= bit_tmr_d;
      bit_idx_q <= bit_idx_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign due_in      = due_in_q;
  assign truth_table = tt_q;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
